// File: rtl/reg_exchange_unit_if.sv
// Request/response channel of the register-exchange unit.
// The master drives commands and consumes responses; the slave is the unit itself.
interface reg_exchange_unit_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data_a;
  logic [WIDTH-1:0]  rsp_data_b;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data_a, rsp_data_b, busy
  );
endinterface

// File: rtl/reg_exchange_unit.sv
// Handshaked register-exchange engine: WRITE/READ/SWAP/ROTATE on a small register file,
// every update of a command committing on one edge; the response carries the pre-update values.
module reg_exchange_unit #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  reg_exchange_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_ROTATE = 2'b11;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] addr_a_reg, addr_b_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic              rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_a_reg, rsp_b_reg;
  logic [WIDTH-1:0]  mem_reg  [DEPTH];
  logic [WIDTH-1:0]  mem_next [DEPTH];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every entry's next value is derived only from the current (old) contents,
  // so one command's updates all land together on the EXEC edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        mem_next[gi] = mem_reg[gi];
        if (state_reg == EXEC) begin
          case (op_reg)
            OP_WRITE:
              if (addr_a_reg == ADDR_W'(gi)) mem_next[gi] = wdata_reg;
            OP_SWAP:
              if (addr_a_reg == ADDR_W'(gi))      mem_next[gi] = mem_reg[addr_b_reg];
              else if (addr_b_reg == ADDR_W'(gi)) mem_next[gi] = mem_reg[addr_a_reg];
            // The ADDR_W cast wraps the last entry back to entry 0.
            OP_ROTATE:
              mem_next[gi] = mem_reg[ADDR_W'(gi + 1)];
            default: ;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      addr_a_reg    <= '0;
      addr_b_reg    <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_a_reg     <= '0;
      rsp_b_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
      if (state_reg == IDLE && bus.req_valid) begin
        op_reg     <= bus.req_op;
        addr_a_reg <= bus.req_addr_a;
        addr_b_reg <= bus.req_addr_b;
        wdata_reg  <= bus.req_wdata;
      end
      if (state_reg == EXEC) begin
        rsp_a_reg     <= mem_reg[addr_a_reg];
        rsp_b_reg     <= mem_reg[addr_b_reg];
        rsp_valid_reg <= 1'b1;
      end else if (state_reg == RESP && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_data_a = rsp_a_reg;
  assign bus.rsp_data_b = rsp_b_reg;
endmodule

// File: tb/tb_reg_exchange_unit.sv
// Randomized self-checking bench for reg_exchange_unit against an array-based reference model.
module tb_reg_exchange_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   check_count = 0;
  int   error_count = 0;
  logic [WIDTH-1:0] model [DEPTH];

  reg_exchange_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_exchange_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Apply a command to the reference model and return the pre-command values.
  task automatic model_apply(input logic [1:0] op, input int a, input int b,
                             input logic [WIDTH-1:0] wd,
                             output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
    logic [WIDTH-1:0] tmp [DEPTH];
    ea = model[a];
    eb = model[b];
    case (op)
      2'b00: model[a] = wd;
      2'b10: begin
        tmp[0]   = model[a];
        model[a] = model[b];
        model[b] = tmp[0];
      end
      2'b11: begin
        for (int i = 0; i < DEPTH; i++) tmp[i] = model[(i + 1) % DEPTH];
        for (int i = 0; i < DEPTH; i++) model[i] = tmp[i];
      end
      default: ;
    endcase
  endtask

  task automatic drive_req(input logic [1:0] op, input int a, input int b, input logic [WIDTH-1:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr_a = a[1:0];
    bus.req_addr_b = b[1:0];
    bus.req_wdata  = wd;
  endtask

  // One full command with fixed expected latency: accept, EXEC, RESP held for 'stall' cycles.
  task automatic run_cmd(input logic [1:0] op, input int a, input int b,
                         input logic [WIDTH-1:0] wd, input int stall);
    logic [WIDTH-1:0] ea, eb;
    model_apply(op, a, b, wd, ea, eb);
    @(negedge clk);
    drive_req(op, a, b, wd);
    check("idle_req_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("exec_busy", bus.busy, 1);
    check("exec_req_ready", bus.req_ready, 0);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_data_a", bus.rsp_data_a, ea);
    check("rsp_data_b", bus.rsp_data_b, eb);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_data_a", bus.rsp_data_a, ea);
      check("stall_data_b", bus.rsp_data_b, eb);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", bus.rsp_valid, 0);
    check("done_req_ready", bus.req_ready, 1);
    $display("cmd op=%0d a=%0d b=%0d wd=%02h stall=%0d -> rsp a=%02h b=%02h",
             op, a, b, wd, stall, ea, eb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data_a"}, bus.rsp_data_a, 0);
    check({tag, "_rsp_data_b"}, bus.rsp_data_b, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ea, eb, hold_a, hold_b;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr_a = '0;
    bus.req_addr_b = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WRITE/WRITE/SWAP then READ back the swapped pair
    run_cmd(2'b00, 0, 3, 8'h11, 0);
    run_cmd(2'b00, 1, 0, 8'h22, 0);
    run_cmd(2'b10, 0, 1, 8'h00, 0);
    run_cmd(2'b01, 0, 1, 8'h00, 0);

    // SWAP of an entry with itself
    run_cmd(2'b00, 2, 0, 8'h5A, 0);
    run_cmd(2'b10, 2, 2, 8'h00, 0);
    run_cmd(2'b01, 2, 2, 8'h00, 0);

    // ROTATE
    run_cmd(2'b00, 0, 0, 8'h10, 0);
    run_cmd(2'b00, 1, 0, 8'h20, 0);
    run_cmd(2'b00, 2, 0, 8'h30, 0);
    run_cmd(2'b00, 3, 0, 8'h40, 0);
    run_cmd(2'b11, 0, 3, 8'h00, 0);
    run_cmd(2'b01, 0, 1, 8'h00, 0);
    run_cmd(2'b01, 2, 3, 8'h00, 0);

    // Backpressure with a competing request held during RESP
    model_apply(2'b01, 2, 3, 8'h00, hold_a, hold_b);
    @(negedge clk);
    drive_req(2'b01, 2, 3, 8'h00);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    drive_req(2'b00, 3, 0, 8'h77);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_a", bus.rsp_data_a, hold_a);
      check("bp_hold_b", bus.rsp_data_b, hold_b);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_released_valid", bus.rsp_valid, 0);
    check("bp_released_ready", bus.req_ready, 1);
    model_apply(2'b00, 3, 0, 8'h77, ea, eb);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_second_accepted", bus.busy, 1);
    @(negedge clk);
    check("bp_second_rsp_a", bus.rsp_data_a, ea);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    $display("cmd backpressure read(2,3) then write 77->3 rsp a=%02h", ea);
    run_cmd(2'b01, 3, 0, 8'h00, 0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(3)), $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
              8'($urandom), $urandom_range(2));
    end

    // Asynchronous reset mid-cycle, no clock edge needed
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    run_cmd(2'b01, 0, 1, 8'h00, 0);
    run_cmd(2'b01, 2, 3, 8'h00, 0);

    // Reset during EXEC of a SWAP aborts it
    run_cmd(2'b00, 0, 0, 8'hA1, 0);
    run_cmd(2'b00, 1, 0, 8'hB2, 0);
    @(negedge clk);
    drive_req(2'b10, 0, 1, 8'h00);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_in_exec", bus.busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    $display("cmd swap(0,1) aborted by reset");
    run_cmd(2'b01, 0, 1, 8'h00, 0);
    run_cmd(2'b01, 2, 3, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end
endmodule
